// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES-128 inverse round engine.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_fsm_e;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply; with a constant operand this folds to a few XORs.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gf_xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_mixcolumns.sv
// InvMixColumns over the full 128-bit state; column c holds bytes 4c..4c+3.
module aes_inv_mixcolumns
    import aes_pkg::*;
(
    input  aes_state_t din,
    output aes_state_t dout
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = din[8*(15-(4*c+0)) +: 8];
        assign a1 = din[8*(15-(4*c+1)) +: 8];
        assign a2 = din[8*(15-(4*c+2)) +: 8];
        assign a3 = din[8*(15-(4*c+3)) +: 8];

        assign dout[8*(15-(4*c+0)) +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                                         ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        assign dout[8*(15-(4*c+1)) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                                         ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        assign dout[8*(15-(4*c+2)) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                                         ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        assign dout[8*(15-(4*c+3)) +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                                         ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end

endmodule

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: inverse affine map, then GF(2^8) inversion.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] aff;
    logic [7:0] base;
    logic [7:0] acc;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            aff[i] = din[(i + 2) % 8] ^ din[(i + 5) % 8] ^ din[(i + 7) % 8];
        end
        aff = aff ^ 8'h05;
        // a^254 == a^-1 (and maps 0 to 0); 254 = 2+4+...+128
        base = aff;
        acc  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            base = gf_mul(base, base);
            acc  = gf_mul(acc, base);
        end
        dout = acc;
    end

endmodule

// File: rtl/aes_inv_round_engine.sv
// Iterative AES-128 decryptor: one inverse round per cycle, round keys fetched by key_idx.
module aes_inv_round_engine
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct_in,
    output logic [3:0]   key_idx,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt_out
);

    aes_fsm_e   state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    aes_state_t blk_q, blk_d;

    aes_state_t isr;
    aes_state_t isb;
    aes_state_t ark;
    aes_state_t imc;

    // InvShiftRows is pure wiring: row r of column c comes from column (c - r) mod 4.
    for (genvar b = 0; b < 16; b++) begin : g_byte
        localparam int ROW = b % 4;
        localparam int COL = b / 4;
        localparam int SRC = 4 * ((COL + 4 - ROW) % 4) + ROW;

        assign isr[8*(15-b) +: 8] = blk_q[8*(15-SRC) +: 8];

        aes_inv_sbox u_sbox (
            .din  (isr[8*(15-b) +: 8]),
            .dout (isb[8*(15-b) +: 8])
        );
    end

    assign ark = isb ^ round_key;

    aes_inv_mixcolumns u_imc (
        .din  (ark),
        .dout (imc)
    );

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        blk_d   = blk_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    blk_d   = ct_in ^ round_key;
                    rnd_d   = 4'(AES_NR - 1);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (rnd_q != 4'd0) begin
                    blk_d = imc;
                    rnd_d = rnd_q - 4'd1;
                end else begin
                    // last round skips InvMixColumns
                    blk_d   = ark;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        key_idx = 4'd0;
        case (state_q)
            IDLE:    key_idx = 4'(AES_NR);
            ROUND:   key_idx = rnd_q;
            default: key_idx = 4'd0;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign pt_out    = blk_q;

endmodule

// File: tb/tb_aes_inv_round_engine.sv
// Bench for aes_inv_round_engine: FIPS inverse-cipher model plus cycle-level handshake model.
module tb_aes_inv_round_engine;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] ct_in = '0;
    logic         in_ready;
    logic         out_valid;
    logic [3:0]   key_idx;
    logic [127:0] round_key;
    logic [127:0] pt_out;

    logic [127:0] sched [0:15];
    logic [7:0]   sbox  [0:255];
    logic [7:0]   isbox [0:255];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_done = 0;
    int done_q[$];

    logic         m_busy = 1'b0;
    int           m_cnt = 0;
    logic [127:0] m_exp = '0;

    assign round_key = sched[key_idx];

    aes_inv_round_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct_in     (ct_in),
        .key_idx   (key_idx),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt_out    (pt_out)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] fmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Forward S-box from a brute-force inverse search, then inverted by table lookup.
    task automatic init_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && fmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox[x] = s;
            isbox[s] = 8'(x);
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            sched[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    // Textbook inverse cipher on a 4x4 byte matrix s[row][col].
    function automatic logic [127:0] model_decrypt(input logic [127:0] ct);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   a [4];
        logic [127:0] pt;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = ct[8*(15-(4*c+r)) +: 8] ^ sched[10][8*(15-(4*c+r)) +: 8];
        for (int rd = 9; rd >= 0; rd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][(c+r)%4] = s[r][c];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = isbox[t[r][c]] ^ sched[rd][8*(15-(4*c+r)) +: 8];
            if (rd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[r][c];
                    s[0][c] = fmul(a[0], 8'h0e) ^ fmul(a[1], 8'h0b) ^ fmul(a[2], 8'h0d) ^ fmul(a[3], 8'h09);
                    s[1][c] = fmul(a[0], 8'h09) ^ fmul(a[1], 8'h0e) ^ fmul(a[2], 8'h0b) ^ fmul(a[3], 8'h0d);
                    s[2][c] = fmul(a[0], 8'h0d) ^ fmul(a[1], 8'h09) ^ fmul(a[2], 8'h0e) ^ fmul(a[3], 8'h0b);
                    s[3][c] = fmul(a[0], 8'h0b) ^ fmul(a[1], 8'h0d) ^ fmul(a[2], 8'h09) ^ fmul(a[3], 8'h0e);
                end
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                pt[8*(15-(4*c+r)) +: 8] = s[r][c];
        return pt;
    endfunction

    // Cycle-level handshake model: cycles since accept decide every output.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst_out_valid", 128'(out_valid), 128'(0));
            check("rst_in_ready", 128'(in_ready), 128'(1));
            check("rst_pt_out", pt_out, 128'h0);
            m_busy = 1'b0;
        end else if (!m_busy) begin
            check("idle_in_ready", 128'(in_ready), 128'(1));
            check("idle_out_valid", 128'(out_valid), 128'(0));
            check("idle_key_idx", 128'(key_idx), 128'(10));
            if (in_valid) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_exp  = model_decrypt(ct_in);
            end
        end else begin
            m_cnt++;
            if (m_cnt <= 10) begin
                check("round_key_idx", 128'(key_idx), 128'(10 - m_cnt));
                check("round_in_ready", 128'(in_ready), 128'(0));
                check("round_out_valid", 128'(out_valid), 128'(0));
            end else begin
                check("done_out_valid", 128'(out_valid), 128'(1));
                check("done_in_ready", 128'(in_ready), 128'(0));
                check("done_key_idx", 128'(key_idx), 128'(0));
                check("done_pt_out", pt_out, m_exp);
                if (m_cnt == 11) done_q.push_back(cyc);
                if (out_ready) begin
                    m_busy = 1'b0;
                    n_done++;
                end
            end
        end
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (i == 300) check("timeout_idle", 128'(0), 128'(1));
    endtask

    task automatic send(input logic [127:0] ct, output int acc);
        int i;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        ct_in    = ct;
        acc      = -1;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (i == 300) check("timeout_accept", 128'(0), 128'(1));
        acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int t);
        int i;
        t = -1;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        if (i == 300) check("timeout_out_valid", 128'(0), 128'(1));
        else t = cyc;
    endtask

    initial begin
        int acc, t, nd, na;
        int acc_t [2];
        logic [127:0] key;

        init_tables();
        expand_key(C1_KEY);
        check("model_c1_rk10", sched[10], C1_RK10);
        check("model_c1_pt", model_decrypt(C1_CT), C1_PT);
        expand_key('0);
        check("model_zero_pt", model_decrypt(Z_CT), 128'h0);
        expand_key(C1_KEY);

        repeat (3) @(posedge clk);
        // Offer the first block together with reset release.
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        ct_in    = C1_CT;
        acc      = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("first_edge_accept", 128'(key_idx), 128'(9));
        wait_out(t);
        check("c1_latency", 128'(t - acc), 128'(11));
        check("c1_pt", pt_out, C1_PT);

        wait_idle();
        expand_key('0);
        send(Z_CT, acc);
        wait_out(t);
        check("zero_latency", 128'(t - acc), 128'(11));
        check("zero_pt", pt_out, 128'h0);

        // Backpressure in DONE with stray in_valid pulses.
        wait_idle();
        expand_key(C1_KEY);
        out_ready = 1'b0;
        send(C1_CT, acc);
        wait_out(t);
        nd = n_done;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'(i % 2 == 0);
            ct_in    = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check("bp_pt_stable", pt_out, C1_PT);
            check("bp_in_ready", 128'(in_ready), 128'(0));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_one_handshake", 128'(n_done - nd), 128'(1));
        check("bp_back_idle", 128'(in_ready), 128'(1));

        // Back-to-back with in_valid held high.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        ct_in    = C1_CT;
        na       = 0;
        acc_t[0] = 0;
        acc_t[1] = 0;
        for (int i = 0; i < 60 && na < 2; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_t[na] = cyc;
                na++;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_accepts", 128'(na), 128'(2));
        check("b2b_accept_gap", 128'(acc_t[1] - acc_t[0]), 128'(12));
        wait_out(t);
        #1;
        check("b2b_pt", pt_out, C1_PT);
        check("b2b_out_gap", 128'(done_q[$] - done_q[$-1]), 128'(12));

        // Reset in the middle of ROUND.
        wait_idle();
        send(C1_CT, acc);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midop_rst_out_valid", 128'(out_valid), 128'(0));
        check("midop_rst_in_ready", 128'(in_ready), 128'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        send(C1_CT, acc);
        wait_out(t);
        check("post_rst_latency", 128'(t - acc), 128'(11));
        check("post_rst_pt", pt_out, C1_PT);

        // Randomized traffic: random keys, ciphertexts, in_valid and out_ready.
        nd = n_done;
        for (int k = 0; k < 6; k++) begin
            wait_idle();
            key = {$urandom, $urandom, $urandom, $urandom};
            expand_key(key);
            for (int i = 0; i < 150; i++) begin
                @(posedge clk);
                #1;
                in_valid  = ($urandom_range(0, 2) == 0);
                ct_in     = {$urandom, $urandom, $urandom, $urandom};
                out_ready = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        wait_idle();
        #1;
        check("random_blocks_done", 128'(n_done - nd > 20), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_inv_round_engine.md
AES_INV_ROUND_ENGINE -- requirements
Module: aes_inv_round_engine

Interface
REQ-001 The module SHALL have no parameters; the round count is fixed at 10 (AES-128).
REQ-002 The port list SHALL be exactly:
  clk  input  1  single clock; all state updates on the rising edge.
  rst_n  input  1  asynchronous, active-low reset.
  in_valid  input  1  ciphertext block offered.
  in_ready  output  1  engine can accept a block.
  ct_in  input  128  ciphertext; byte i = ct_in[8*(15-i)+:8], column c = bytes 4c..4c+3.
  key_idx  output  4  round-key index requested (0..10).
  round_key  input  128  expanded round key for key_idx; valid combinationally in the same cycle; same byte order as ct_in.
  out_valid  output  1  plaintext available.
  out_ready  input  1  consumer accepts plaintext.
  pt_out  output  128  plaintext; same byte order as ct_in.
REQ-003 The module SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 The FSM SHALL have exactly the states IDLE, ROUND, DONE.
REQ-005 In IDLE: in_ready=1 and key_idx=10; on in_valid, the state register SHALL load ct_in XOR round_key, rnd SHALL load 9, and the FSM SHALL go to ROUND.
REQ-006 In ROUND: in_ready=0 and key_idx=rnd; each cycle SHALL apply InvShiftRows, then InvSubBytes, then XOR round_key; when rnd>=1 the result SHALL then pass through InvMixColumns.
REQ-007 In ROUND: when rnd>=1, rnd SHALL decrement by 1; when rnd==0, the result SHALL be the final plaintext and the FSM SHALL go to DONE.
REQ-008 InvShiftRows SHALL rotate row r right by r columns; row r of column c is byte 4c+r.
REQ-009 In DONE: out_valid=1 and pt_out=state register; the FSM SHALL hold until out_valid && out_ready, then return to IDLE.
REQ-010 The block SHALL NOT accept new input while in DONE (in_ready=0).
REQ-011 Latency SHALL be 11 cycles from the accept edge to out_valid high.
REQ-012 Minimum block period SHALL be 12 cycles when out_ready is held high.
REQ-013 pt_out SHALL be stable while out_valid=1 and out_ready=0.
REQ-014 in_valid asserted outside IDLE SHALL be ignored with no side effect.
REQ-015 key_idx SHALL be a pure function of FSM state and rnd; in DONE, key_idx=0.
REQ-016 rnd SHALL never wrap below 0; rnd values 10..15 SHALL be unreachable.

Reset
REQ-017 While rst_n=0, the engine SHALL hold state=IDLE, rnd=0, state register=0, out_valid=0 and in_ready=1.
REQ-018 Asserting rst_n low mid-decryption or in DONE SHALL abort immediately; no stale out_valid SHALL appear after release.
REQ-019 The first in_valid is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-020 Package aes_pkg SHALL hold: AES_NR=10, the FSM state enum, and the 128-bit state typedef.
REQ-021 The round datapath SHALL instantiate the existing aes_inv_mixcolumns.
REQ-022 One sub-module, aes_inv_sbox (8-bit in, 8-bit out, combinational inverse S-box), SHALL be instantiated 16 times.
REQ-023 The round datapath SHALL be combinational from the state register to the state register; only the FSM, rnd and the state register are flops.

Verification
REQ-024 FIPS-197 C.1 (key 000102…0f, bench-supplied schedule): ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, out_valid exactly 11 cycles after accept.
REQ-025 Key-index trace for one block: key_idx sequence 10,9,8,…,1,0 on consecutive cycles starting at the accept cycle.
REQ-026 Backpressure: out_ready=0 for 5 cycles in DONE -> pt_out stable, in_ready=0, and in_valid pulses ignored; release -> one handshake, then IDLE.
REQ-027 Back-to-back: two C.1 blocks with in_valid held high and out_ready=1 -> two correct outputs 12 cycles apart.
REQ-028 Reset mid-op: rst_n low at cycle 5 of ROUND -> out_valid=0, in_ready=1; a fresh block after release decrypts correctly.
REQ-029 All-zero key and ct 66e94bd4ef8a2c3b884cfa59ca342b2e -> pt 00000000000000000000000000000000.
